// File: rtl/axis_pkt_arbiter.sv
// Two-source AXI-Stream packet arbiter: one grant per packet (round-robin or
// fixed priority), single registered output stage, per-source packet counters.
module axis_pkt_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  prio_mode,
    input  logic [DATA_WIDTH-1:0] input_tdata_0,
    input  logic                  input_tvalid_0,
    output logic                  input_tready_0,
    input  logic                  input_tlast_0,
    input  logic [DATA_WIDTH-1:0] input_tdata_1,
    input  logic                  input_tvalid_1,
    output logic                  input_tready_1,
    input  logic                  input_tlast_1,
    output logic [DATA_WIDTH-1:0] output_data,
    output logic                  output_valid,
    output logic                  output_last,
    input  logic                  output_ready,
    output logic                  sel,
    output logic                  busy,
    output logic [CNT_WIDTH-1:0]  pkt_count_0,
    output logic [CNT_WIDTH-1:0]  pkt_count_1
);
    typedef enum logic {IDLE, PKT} state_t;

    state_t                r_state;
    logic                  r_sel;
    logic                  r_busy;
    logic                  r_last_grant;
    logic                  r_out_valid;
    logic                  r_out_last;
    logic [DATA_WIDTH-1:0] r_out_data;
    logic [CNT_WIDTH-1:0]  r_cnt0;
    logic [CNT_WIDTH-1:0]  r_cnt1;

    logic                  w_ready;
    logic                  w_tvalid;
    logic                  w_tlast;
    logic [DATA_WIDTH-1:0] w_tdata;
    logic                  w_accept;
    logic                  w_grant;

    // The output register can take a new beat when empty or draining this cycle.
    assign w_ready  = (r_state == PKT) && (!r_out_valid || output_ready);
    assign w_tvalid = r_sel ? input_tvalid_1 : input_tvalid_0;
    assign w_tlast  = r_sel ? input_tlast_1  : input_tlast_0;
    assign w_tdata  = r_sel ? input_tdata_1  : input_tdata_0;
    assign w_accept = w_ready && w_tvalid;

    assign input_tready_0 = w_ready && !r_sel;
    assign input_tready_1 = w_ready &&  r_sel;

    always_comb begin
        w_grant = input_tvalid_1;
        if (input_tvalid_0 && input_tvalid_1)
            w_grant = prio_mode ? 1'b0 : ~r_last_grant;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= IDLE;
            r_sel        <= 1'b0;
            r_busy       <= 1'b0;
            r_last_grant <= 1'b1;
            r_out_valid  <= 1'b0;
            r_out_last   <= 1'b0;
            r_out_data   <= '0;
            r_cnt0       <= '0;
            r_cnt1       <= '0;
        end else begin
            if (w_accept) begin
                r_out_data  <= w_tdata;
                r_out_last  <= w_tlast;
                r_out_valid <= 1'b1;
            end else if (output_ready) begin
                r_out_valid <= 1'b0;
                r_out_last  <= 1'b0;
            end

            case (r_state)
                IDLE: begin
                    if (input_tvalid_0 || input_tvalid_1) begin
                        r_sel   <= w_grant;
                        r_busy  <= 1'b1;
                        r_state <= PKT;
                    end
                end
                PKT: begin
                    // Grant is held until the tlast beat is taken.
                    if (w_accept && w_tlast) begin
                        r_last_grant <= r_sel;
                        if (r_sel) r_cnt1 <= r_cnt1 + 1'b1;
                        else       r_cnt0 <= r_cnt0 + 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign output_data  = r_out_data;
    assign output_valid = r_out_valid;
    assign output_last  = r_out_last;
    assign sel          = r_sel;
    assign busy         = r_busy;
    assign pkt_count_0  = r_cnt0;
    assign pkt_count_1  = r_cnt1;
endmodule

// File: tb/tb_axis_pkt_arbiter.sv
// Scoreboard bench for axis_pkt_arbiter: packet-order reference model, source
// drivers with randomized sink backpressure, and a negedge output monitor.
module tb_axis_pkt_arbiter;
    localparam int DW = 8;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          prio_mode = 1'b0;
    logic [DW-1:0] input_tdata_0 = '0, input_tdata_1 = '0;
    logic          input_tvalid_0 = 1'b0, input_tvalid_1 = 1'b0;
    logic          input_tlast_0 = 1'b0, input_tlast_1 = 1'b0;
    logic          input_tready_0, input_tready_1;
    logic [DW-1:0] output_data;
    logic          output_valid, output_last;
    logic          output_ready = 1'b1;
    logic          sel, busy;
    logic [CW-1:0] pkt_count_0, pkt_count_1;

    axis_pkt_arbiter #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .clk(clk), .reset(reset), .prio_mode(prio_mode),
        .input_tdata_0(input_tdata_0), .input_tvalid_0(input_tvalid_0),
        .input_tready_0(input_tready_0), .input_tlast_0(input_tlast_0),
        .input_tdata_1(input_tdata_1), .input_tvalid_1(input_tvalid_1),
        .input_tready_1(input_tready_1), .input_tlast_1(input_tlast_1),
        .output_data(output_data), .output_valid(output_valid),
        .output_last(output_last), .output_ready(output_ready),
        .sel(sel), .busy(busy),
        .pkt_count_0(pkt_count_0), .pkt_count_1(pkt_count_1)
    );

    always #5 clk = ~clk;

    typedef struct { logic [7:0] d; logic l; logic f; } beat_t;
    typedef struct { logic [7:0] d; logic l; logic s; } exp_t;

    beat_t q0[$], q1[$], p0[$], p1[$];
    int    len0[$], len1[$];
    exp_t  exp_q[$];
    int    stamps[$];
    int    checks = 0, errors = 0, cyc = 0;
    bit    mon_en = 0, en0 = 0, en1 = 0, bub = 0, chk_prio = 0, acc0 = 0, acc1 = 0;
    int    rdy_mode = 0;
    int    m_lg = 1, m_cnt0 = 0, m_cnt1 = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    initial forever begin @(posedge clk); cyc++; end
    initial forever begin
        @(negedge clk);
        acc0 = input_tvalid_0 && input_tready_0;
        acc1 = input_tvalid_1 && input_tready_1;
    end

    // Source drivers and sink ready, updated just after each rising edge.
    initial forever begin
        @(posedge clk); #1;
        if (acc0 && q0.size() > 0) void'(q0.pop_front());
        if (acc1 && q1.size() > 0) void'(q1.pop_front());
        case (rdy_mode)
            0:       output_ready = 1'b1;
            1:       output_ready = !output_ready;
            2:       output_ready = 1'($urandom_range(0, 1));
            default: output_ready = 1'b0;
        endcase
        input_tvalid_0 = 1'b0; input_tvalid_1 = 1'b0;
        if (q0.size() > 0) begin
            input_tdata_0 = q0[0].d; input_tlast_0 = q0[0].l;
            input_tvalid_0 = en0 && !(bub && !q0[0].f && $urandom_range(0, 3) == 0);
        end
        if (q1.size() > 0) begin
            input_tdata_1 = q1[0].d; input_tlast_1 = q1[0].l;
            input_tvalid_1 = en1 && !(bub && !q1[0].f && $urandom_range(0, 3) == 0);
        end
    end

    // Output monitor / scoreboard.
    logic          pv = 0, pr = 0, pl = 0, pb = 0, ps = 0;
    logic [DW-1:0] pd = '0;
    initial forever begin
        exp_t e;
        @(negedge clk);
        if (mon_en) begin
            if (pv && !pr) begin
                chk("hold_valid", output_valid, 1);
                chk("hold_data", output_data, pd);
                chk("hold_last", output_last, pl);
            end
            if (pb && busy) chk("sel_stable", sel, ps);
            if (busy) chk("tready_nonsel", sel ? input_tready_0 : input_tready_1, 0);
            else      chk("tready_idle", {input_tready_0, input_tready_1}, 0);
            if (chk_prio) chk("prio_tready1", input_tready_1, 0);
            if (output_valid && output_ready) begin
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_beat act=%0h exp=none", output_data);
                end else begin
                    e = exp_q.pop_front();
                    chk("out_data", output_data, e.d);
                    chk("out_last", output_last, e.l);
                    if (busy && !e.l) chk("sel_src", sel, e.s);
                    stamps.push_back(cyc);
                end
            end
            pv = output_valid; pr = output_ready; pd = output_data;
            pl = output_last; pb = busy; ps = sel;
        end else begin
            pv = 0; pb = 0;
        end
    end

    task automatic do_reset();
        mon_en = 0; en0 = 0; en1 = 0; chk_prio = 0; bub = 0; prio_mode = 0;
        @(posedge clk); #2;
        reset = 1;
        @(posedge clk); #2;
        q0.delete(); q1.delete(); exp_q.delete(); stamps.delete();
        reset = 0;
        m_lg = 1; m_cnt0 = 0; m_cnt1 = 0;
        mon_en = 1;
    endtask

    task automatic add_pkt(input int s, input int n, input logic [7:0] d0, input logic [7:0] st);
        beat_t b;
        for (int k = 0; k < n; k++) begin
            b.d = d0 + 8'(k) * st; b.l = (k == n - 1); b.f = (k == 0);
            if (s == 0) p0.push_back(b); else p1.push_back(b);
        end
        if (s == 0) len0.push_back(n); else len1.push_back(n);
    endtask

    // Reference model: whole-packet grant order from the arbitration rules.
    task automatic run_batch(input bit prio);
        int i = 0, j = 0, bi = 0, bj = 0, s;
        prio_mode = prio;
        while (i < len0.size() || j < len1.size()) begin
            if (i < len0.size() && j < len1.size()) s = prio ? 0 : (m_lg == 0 ? 1 : 0);
            else s = (i < len0.size()) ? 0 : 1;
            if (s == 0) begin
                for (int k = 0; k < len0[i]; k++) begin
                    exp_q.push_back('{p0[bi].d, p0[bi].l, 1'b0}); bi++;
                end
                i++; m_cnt0++;
            end else begin
                for (int k = 0; k < len1[j]; k++) begin
                    exp_q.push_back('{p1[bj].d, p1[bj].l, 1'b1}); bj++;
                end
                j++; m_cnt1++;
            end
            m_lg = s;
        end
        foreach (p0[k]) q0.push_back(p0[k]);
        foreach (p1[k]) q1.push_back(p1[k]);
        p0.delete(); p1.delete(); len0.delete(); len1.delete();
        en0 = 1; en1 = 1;
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (!(exp_q.size() == 0 && q0.size() == 0 && q1.size() == 0 && !busy && !output_valid)
               && n < 5000) begin
            @(negedge clk); n++;
        end
        chk({name, "_done"}, n < 5000, 1);
        chk({name, "_cnt0"}, pkt_count_0, m_cnt0 % (1 << CW));
        chk({name, "_cnt1"}, pkt_count_1, m_cnt1 % (1 << CW));
    endtask

    task automatic chk_gaps(input string name, input int n, input int pkt_len, input int between);
        chk({name, "_nbeats"}, stamps.size(), n);
        for (int k = 1; k < stamps.size() && k < n; k++)
            chk({name, "_gap"}, stamps[k] - stamps[k-1], (k % pkt_len == 0) ? between : 1);
    endtask

    initial begin
        int n;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", output_valid, 0);
        chk("rst_last", output_last, 0);
        chk("rst_data", output_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_sel", sel, 0);
        chk("rst_cnt0", pkt_count_0, 0);
        chk("rst_cnt1", pkt_count_1, 0);
        chk("rst_tready", {input_tready_0, input_tready_1}, 0);
        @(posedge clk); #2;
        reset = 0; mon_en = 1;

        // Single 3-beat packet from source 0, full rate.
        do_reset(); rdy_mode = 0;
        add_pkt(0, 3, 8'h11, 8'h11);
        run_batch(0); wait_done("s_basic");
        chk_gaps("s_basic", 3, 3, 2);
        chk("s_basic_busy", busy, 0);

        // Round-robin alternation with one idle cycle between packets.
        do_reset();
        add_pkt(0, 2, 8'hA0, 1); add_pkt(0, 2, 8'hA0, 1);
        add_pkt(1, 2, 8'hB0, 1); add_pkt(1, 2, 8'hB0, 1);
        run_batch(0); wait_done("s_rr");
        chk_gaps("s_rr", 8, 2, 2);
        chk("s_rr_cnt0_abs", pkt_count_0, 2);

        // Fixed priority: source 0 keeps winning while it has packets.
        do_reset();
        for (int k = 0; k < 3; k++) add_pkt(0, 2, 8'hC0 + 8'(2 * k), 1);
        add_pkt(1, 2, 8'hD0, 1);
        chk_prio = 1;
        run_batch(1);
        n = 0;
        while (pkt_count_0 != 3 && n < 1000) begin @(negedge clk); n++; end
        chk_prio = 0;
        chk("s_prio_reach", n < 1000, 1);
        chk("s_prio_cnt1", pkt_count_1, 0);
        wait_done("s_prio");

        // Toggling backpressure on a source 1 packet.
        do_reset(); rdy_mode = 1;
        add_pkt(1, 3, 8'h55, 1);
        run_batch(0); wait_done("s_bp");
        chk("s_bp_n", stamps.size(), 3);
        rdy_mode = 0;

        // Source 0 becomes valid in the middle of a source 1 packet.
        do_reset();
        add_pkt(1, 5, 8'h60, 1);
        for (int k = 0; k < 5; k++) exp_q.push_back('{p1[k].d, p1[k].l, 1'b1});
        add_pkt(0, 2, 8'h70, 1);
        for (int k = 0; k < 2; k++) exp_q.push_back('{p0[k].d, p0[k].l, 1'b0});
        foreach (p0[k]) q0.push_back(p0[k]);
        foreach (p1[k]) q1.push_back(p1[k]);
        p0.delete(); p1.delete(); len0.delete(); len1.delete();
        m_cnt0 = 1; m_cnt1 = 1; m_lg = 0;
        en1 = 1;
        n = 0;
        while (exp_q.size() > 5 && n < 1000) begin @(negedge clk); n++; end
        chk("s_mid_reach", n < 1000, 1);
        en0 = 1;
        wait_done("s_mid");
        chk_gaps("s_mid", 7, 5, 2);

        // Counter wrap with single-beat packets (2 cycles each).
        do_reset();
        for (int k = 0; k < (1 << CW) - 1; k++) add_pkt(0, 1, 8'(k), 0);
        run_batch(0); wait_done("s_wrap_pre");
        chk("s_wrap_max", pkt_count_0, (1 << CW) - 1);
        chk_gaps("s_wrap_single", (1 << CW) - 1, 1, 2);
        add_pkt(0, 1, 8'hEE, 0);
        run_batch(0); wait_done("s_wrap");
        chk("s_wrap_zero", pkt_count_0, 0);

        // Reset after the first beat of a 3-beat packet.
        do_reset(); rdy_mode = 3;
        add_pkt(0, 3, 8'h90, 1);
        run_batch(0);
        n = 0;
        while (!output_valid && n < 100) begin @(negedge clk); n++; end
        chk("s_rstmid_beat1", output_data, 8'h90);
        mon_en = 0; reset = 1;
        @(negedge clk);
        chk("s_rstmid_valid", output_valid, 0);
        chk("s_rstmid_busy", busy, 0);
        chk("s_rstmid_cnt0", pkt_count_0, 0);
        rdy_mode = 0;
        do_reset();

        // Randomized batches: random lengths, data, mode, ready and source bubbles.
        do_reset(); rdy_mode = 2; bub = 1;
        for (int b = 0; b < 8; b++) begin
            for (int k = $urandom_range(0, 5); k > 0; k--)
                add_pkt(0, $urandom_range(1, 4), 8'($urandom), 8'($urandom_range(1, 3)));
            for (int k = $urandom_range(0, 5); k > 0; k--)
                add_pkt(1, $urandom_range(1, 4), 8'($urandom), 8'($urandom_range(1, 3)));
            run_batch(1'($urandom_range(0, 1)));
            wait_done("s_rand");
        end
        rdy_mode = 0; bub = 0;

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
